control_unit_fsm: RTL

Multi-cycle sequencer for the OTTER RV32I core. Steps every instruction through fetch, execute and optional load writeback. Generates all write and read enables for the PC, register file, memory and CSR file. Latches external interrupts and produces `int_taken`, which feeds the combinational decoder directly downstream so it can select the trap vector as the next PC.

---
 rtl/control_unit_fsm.sv | 134 +++++++++++++
 1 files changed

// File: rtl/control_unit_fsm.sv
// Multi-cycle fetch/execute/writeback sequencer for the OTTER RV32I core.
// Define CU_INTR_EN to build in the interrupt latch and the INTR state.
module control_unit_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  input  logic       mie,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  state_t cur_state;
  logic   take_intr;

  assign state = cur_state;

`ifdef CU_INTR_EN
  localparam logic INTR_EN = 1'b1;
  logic intr_pending;

  // Clearing in the INTR cycle wins; a level still high is re-captured next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_pending <= 1'b0;
    end else begin
      intr_pending <= (intr_pending | intr) & (cur_state != ST_INTR);
    end
  end

  assign take_intr = intr_pending & mie;
`else
  localparam logic INTR_EN = 1'b0;
  logic unused_intr_inputs;

  assign unused_intr_inputs = intr ^ mie;
  assign take_intr          = 1'b0;
`endif

  // Loads always finish WB before an interrupt is honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= ST_INIT;
    end else begin
      case (cur_state)
        ST_INIT:  cur_state <= ST_FETCH;
        ST_FETCH: cur_state <= ST_EXEC;
        ST_EXEC: begin
          if (opcode == OP_LOAD)  cur_state <= ST_WB;
          else if (take_intr)     cur_state <= ST_INTR;
          else                    cur_state <= ST_FETCH;
        end
        ST_WB:    cur_state <= take_intr ? ST_INTR : ST_FETCH;
        ST_INTR:  cur_state <= ST_FETCH;
        default:  cur_state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    pc_write  = 1'b0;
    reg_write = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    case (cur_state)
      ST_FETCH: mem_rden1 = 1'b1;
      ST_EXEC: begin
        case (opcode)
          OP_LOAD:  mem_rden2 = 1'b1;
          OP_STORE: begin
            mem_we2  = 1'b1;
            pc_write = 1'b1;
          end
          OP_BRANCH: pc_write = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RTYPE: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          OP_SYS: begin
            pc_write = 1'b1;
            if (func3 == 3'b000) begin
              mret_exec = 1'b1;
            end else if (func3 == 3'b001) begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end
          end
          default: pc_write = 1'b1;
        endcase
      end
      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
      end
      ST_INTR: begin
        int_taken = INTR_EN;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
